// File: rtl/r5p_htif_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | r5p_htif_pkg: HTIF mailbox offsets, command codes and shared types   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package r5p_htif_pkg;

  localparam logic [3:0] OFF_TOHOST_LO   = 4'h0;
  localparam logic [3:0] OFF_TOHOST_HI   = 4'h4;
  localparam logic [3:0] OFF_FROMHOST_LO = 4'h8;
  localparam logic [3:0] OFF_FROMHOST_HI = 4'hC;

  localparam logic [7:0] HTIF_DEV_SYS  = 8'd0;
  localparam logic [7:0] HTIF_DEV_CON  = 8'd1;
  localparam logic [7:0] HTIF_CMD_PUTC = 8'd1;

  // FROMHOST_HI value acknowledging a console putchar (dev=1, cmd=1)
  localparam logic [31:0] FROMHOST_PUTC_ACK = 32'h0101_0000;

  typedef enum logic [0:0] {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_t;

  typedef struct packed {
    logic [7:0]  dev;
    logic [7:0]  cmd;
    logic [47:0] payload;
  } tohost_t;

  function automatic logic [31:0] ben_merge(input logic [31:0] old,
                                            input logic [31:0] wdt,
                                            input logic [3:0]  ben);
    logic [31:0] res;
    res = old;
    for (int b = 0; b < 4; b++) begin
      if (ben[b]) res[8*b +: 8] = wdt[8*b +: 8];
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tcb_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tcb_if: tightly coupled bus, fixed 1-cycle response latency          |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface tcb_if #(
  parameter int unsigned ABW = 32,
  parameter int unsigned DBW = 32,
  parameter int unsigned SLW = 8
) ();

  typedef struct packed {
    logic               wen;
    logic [ABW-1:0]     adr;
    logic [DBW/SLW-1:0] ben;
    logic [DBW-1:0]     wdt;
  } req_t;

  typedef struct packed {
    logic err;
  } sts_t;

  typedef struct packed {
    logic [DBW-1:0] rdt;
    sts_t           sts;
  } rsp_t;

  logic vld;
  logic rdy;
  req_t req;
  rsp_t rsp;

  modport man (output vld, output req, input  rdy, input  rsp);
  modport sub (input  vld, input  req, output rdy, output rsp);

endinterface
`default_nettype wire

// File: rtl/r5p_htif_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | r5p_htif_fifo: synchronous FIFO with wrap-bit pointers               |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module r5p_htif_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned DW    = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [DW-1:0]            dat_i,
  input  logic                     pop_i,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   cnt_o,
  output logic [DW-1:0]            dat_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW:0]   wr_q;
  logic [AW:0]   rd_q;
  logic          w_wen;
  logic          w_ren;

  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign empty_o = (wr_q == rd_q);
  assign cnt_o   = wr_q - rd_q;
  assign w_wen   = push_i && !full_o;
  assign w_ren   = pop_i && !empty_o;
  // Head is forced to zero when empty so stale entries never leak out
  assign dat_o   = empty_o ? '0 : mem_q[rd_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (w_wen) wr_q <= wr_q + (AW+1)'(1);
      if (w_ren) rd_q <= rd_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_wen) mem_q[wr_q[AW-1:0]] <= dat_i;
  end

endmodule
`default_nettype wire

// File: rtl/r5p_htif.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | r5p_htif: HTIF tohost/fromhost mailbox with exit and console decode  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module r5p_htif
  import r5p_htif_pkg::*;
#(
  parameter logic [31:0] ADR_BAS    = 32'h8000_1000,
  parameter logic [31:0] ADR_MSK    = 32'h803f_fff0,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  tcb_if.sub          tcb,
  output logic        halt,
  output logic [30:0] exit_code,
  output logic        con_vld,
  output logic [7:0]  con_dat,
  input  logic        con_rdy
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned OW = CW + 1;

  state_t      state_q, state_d;
  tohost_t     tohost_q, tohost_d;
  logic [31:0] fh_lo_q, fh_lo_d;
  logic [31:0] fh_hi_q, fh_hi_d;
  logic [30:0] code_q, code_d;
  logic        push_q, push_d;
  logic [7:0]  push_dat_q, push_dat_d;
  logic [31:0] rdt_q, rdt_d;
  logic        err_q, err_d;
  logic        rdy_q, rdy_d;

  logic          w_trn;
  logic          w_hit;
  logic [1:0]    w_off;
  logic          w_pop;
  logic          w_push;
  logic          w_full;
  logic          w_empty;
  logic [CW-1:0] w_cnt;
  logic [OW-1:0] w_occ;

  assign w_trn = tcb.vld && tcb.rdy;
  assign w_hit = ((tcb.req.adr & ADR_MSK) == ADR_BAS);
  assign w_off = tcb.req.adr[3:2];

  always_comb begin
    state_d    = state_q;
    tohost_d   = tohost_q;
    fh_lo_d    = fh_lo_q;
    fh_hi_d    = fh_hi_q;
    code_d     = code_q;
    push_d     = 1'b0;
    push_dat_d = push_dat_q;
    rdt_d      = '0;
    err_d      = 1'b0;
    if (w_trn) begin
      if (!w_hit) begin
        err_d = 1'b1;
      end else begin
        case (w_off)
          OFF_TOHOST_LO[3:2]:   rdt_d = tohost_q[31:0];
          OFF_TOHOST_HI[3:2]:   rdt_d = tohost_q[63:32];
          OFF_FROMHOST_LO[3:2]: rdt_d = fh_lo_q;
          default:              rdt_d = fh_hi_q;
        endcase
        if (tcb.req.wen) begin
          case (w_off)
            OFF_TOHOST_LO[3:2]:   tohost_d[31:0]  = ben_merge(tohost_q[31:0],  tcb.req.wdt, tcb.req.ben);
            OFF_TOHOST_HI[3:2]:   tohost_d[63:32] = ben_merge(tohost_q[63:32], tcb.req.wdt, tcb.req.ben);
            OFF_FROMHOST_LO[3:2]: fh_lo_d         = ben_merge(fh_lo_q,         tcb.req.wdt, tcb.req.ben);
            default:              fh_hi_d         = ben_merge(fh_hi_q,         tcb.req.wdt, tcb.req.ben);
          endcase
          // Commit decodes the merged LO word together with the stored HI word
          if ((w_off == OFF_TOHOST_LO[3:2]) && tcb.req.ben[0] && (state_q == RUN)) begin
            if ((tohost_d.dev == HTIF_DEV_SYS) && tohost_d.payload[0]) begin
              state_d  = HALTED;
              code_d   = tohost_d.payload[31:1];
              tohost_d = '0;
            end else if ((tohost_d.dev == HTIF_DEV_CON) && (tohost_d.cmd == HTIF_CMD_PUTC)) begin
              push_d     = 1'b1;
              push_dat_d = tohost_d.payload[7:0];
              tohost_d   = '0;
              fh_hi_d    = FROMHOST_PUTC_ACK;
              fh_lo_d    = '0;
            end
          end
        end
      end
    end
  end

  // Occupancy counts the staged push too, so rdy drops before the FIFO can overflow
  assign w_push = push_q && !w_full;
  assign w_pop  = con_vld && con_rdy;
  assign w_occ  = OW'(w_cnt) + OW'(w_push) + OW'(push_d) - OW'(w_pop);
  assign rdy_d  = (w_occ < OW'(FIFO_DEPTH));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      tohost_q   <= '0;
      fh_lo_q    <= '0;
      fh_hi_q    <= '0;
      code_q     <= '0;
      push_q     <= 1'b0;
      push_dat_q <= '0;
      rdt_q      <= '0;
      err_q      <= 1'b0;
      rdy_q      <= 1'b1;
    end else begin
      state_q    <= state_d;
      tohost_q   <= tohost_d;
      fh_lo_q    <= fh_lo_d;
      fh_hi_q    <= fh_hi_d;
      code_q     <= code_d;
      push_q     <= push_d;
      push_dat_q <= push_dat_d;
      rdt_q      <= rdt_d;
      err_q      <= err_d;
      rdy_q      <= rdy_d;
    end
  end

  r5p_htif_fifo #(
    .DEPTH (FIFO_DEPTH),
    .DW    (8)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (w_push),
    .dat_i   (push_dat_q),
    .pop_i   (w_pop),
    .full_o  (w_full),
    .empty_o (w_empty),
    .cnt_o   (w_cnt),
    .dat_o   (con_dat)
  );

  assign con_vld         = !w_empty;
  assign halt            = (state_q == HALTED);
  assign exit_code       = code_q;
  assign tcb.rdy         = rdy_q;
  assign tcb.rsp.rdt     = rdt_q;
  assign tcb.rsp.sts.err = err_q;

endmodule
`default_nettype wire

// File: tb/tb_r5p_htif.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_r5p_htif: directed self-checking bench for the HTIF mailbox       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_r5p_htif;

  localparam logic [31:0] BAS  = 32'h8000_1000;
  localparam logic [31:0] TLO  = BAS + 32'h0;
  localparam logic [31:0] THI  = BAS + 32'h4;
  localparam logic [31:0] FLO  = BAS + 32'h8;
  localparam logic [31:0] FHI  = BAS + 32'hC;

  logic        clk = 1'b0;
  logic        rst;
  logic        halt;
  logic [30:0] exit_code;
  logic        con_vld;
  logic [7:0]  con_dat;
  logic        con_rdy;

  int npass = 0;
  int nfail = 0;
  int ntot  = 0;

  logic [31:0] rd;
  logic        er;
  logic [7:0]  got [$];

  tcb_if tcb ();

  r5p_htif dut (
    .clk       (clk),
    .rst       (rst),
    .tcb       (tcb),
    .halt      (halt),
    .exit_code (exit_code),
    .con_vld   (con_vld),
    .con_dat   (con_dat),
    .con_rdy   (con_rdy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntot++;
    assert (obs === exp) begin
      npass++;
    end else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Returns at the negedge after the transfer, where rsp is valid
  task automatic access(input logic wen, input logic [31:0] adr, input logic [3:0] ben,
                        input logic [31:0] wdt, output logic [31:0] rdt, output logic err);
    int n;
    n = 0;
    @(negedge clk);
    tcb.vld = 1'b1; tcb.req.wen = wen; tcb.req.adr = adr; tcb.req.ben = ben; tcb.req.wdt = wdt;
    while (!tcb.rdy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!tcb.rdy) begin
      check("access_timeout", {63'd0, tcb.rdy}, 64'd1);
      tcb.vld = 1'b0;
      rdt = '0;
      err = 1'b0;
      return;
    end
    @(negedge clk);
    tcb.vld = 1'b0;
    rdt = tcb.rsp.rdt;
    err = tcb.rsp.sts.err;
  endtask

  task automatic wr(input logic [31:0] adr, input logic [31:0] wdt);
    logic [31:0] r;
    logic        e;
    access(1'b1, adr, 4'hF, wdt, r, e);
  endtask

  task automatic rd_check(input string tag, input logic [31:0] adr, input logic [31:0] exp);
    logic [31:0] r;
    logic        e;
    access(1'b0, adr, 4'hF, 32'h0, r, e);
    check(tag, {32'd0, r}, {32'd0, exp});
    check({tag, "_err"}, {63'd0, e}, 64'd0);
  endtask

  task automatic putc(input logic [7:0] b);
    wr(THI, 32'h0101_0000);
    wr(TLO, {24'h0, b});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; con_rdy = 1'b0;
    tcb.vld = 1'b0; tcb.req.wen = 1'b0; tcb.req.adr = '0; tcb.req.ben = '0; tcb.req.wdt = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    check("rst_halt",  {63'd0, halt}, 64'd0);
    check("rst_code",  {33'd0, exit_code}, 64'd0);
    check("rst_cvld",  {63'd0, con_vld}, 64'd0);
    check("rst_cdat",  {56'd0, con_dat}, 64'd0);
    check("rst_rdy",   {63'd0, tcb.rdy}, 64'd1);
    check("rst_rdt",   {32'd0, tcb.rsp.rdt}, 64'd0);
    check("rst_err",   {63'd0, tcb.rsp.sts.err}, 64'd0);

    // putchar 'A' with a ready sink: con_vld appears two cycles after trn
    con_rdy = 1'b1;
    putc(8'h41);
    check("putc_early", {63'd0, con_vld}, 64'd0);
    @(negedge clk);
    check("putc_vld", {63'd0, con_vld}, 64'd1);
    check("putc_dat", {56'd0, con_dat}, 64'h41);
    @(negedge clk);
    check("putc_popped", {63'd0, con_vld}, 64'd0);
    rd_check("putc_fh_hi", FHI, 32'h0101_0000);
    rd_check("putc_fh_lo", FLO, 32'h0);
    rd_check("putc_th_lo", TLO, 32'h0);
    rd_check("putc_th_hi", THI, 32'h0);

    // unmapped address
    access(1'b0, BAS + 32'h20, 4'hF, 32'h0, rd, er);
    check("bad_rd_rdt", {32'd0, rd}, 64'd0);
    check("bad_rd_err", {63'd0, er}, 64'd1);
    access(1'b1, BAS + 32'h2C, 4'hF, 32'hFFFF_FFFF, rd, er);
    check("bad_wr_err", {63'd0, er}, 64'd1);
    rd_check("bad_wr_noeff", FHI, 32'h0101_0000);

    // byte-lane write and non-committing commands
    access(1'b1, THI, 4'b0100, 32'h55AA_6677, rd, er);
    rd_check("ben_th_hi", THI, 32'h00AA_0000);
    wr(TLO, 32'h0000_0002);
    rd_check("nocmd_th_lo", TLO, 32'h0000_0002);
    check("nocmd_halt", {63'd0, halt}, 64'd0);
    wr(THI, 32'h0102_0000);
    wr(TLO, 32'h0000_0042);
    rd_check("badcmd_th_lo", TLO, 32'h0000_0042);
    rd_check("badcmd_th_hi", THI, 32'h0102_0000);
    check("badcmd_cvld", {63'd0, con_vld}, 64'd0);

    // fill the FIFO with a stalled sink, fifth putchar must stall
    con_rdy = 1'b0;
    putc(8'h61); putc(8'h62); putc(8'h63); putc(8'h64);
    check("full_rdy", {63'd0, tcb.rdy}, 64'd0);
    fork
      putc(8'h65);
      begin
        repeat (5) @(negedge clk);
        check("stall_rdy", {63'd0, tcb.rdy}, 64'd0);
        check("stall_cvld", {63'd0, con_vld}, 64'd1);
        check("stall_cdat", {56'd0, con_dat}, 64'h61);
        con_rdy = 1'b1;
        for (int i = 0; i < 40; i++) begin
          if (con_vld) got.push_back(con_dat);
          @(negedge clk);
        end
      end
    join
    check("drain_cnt", 64'(got.size()), 64'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < got.size()) check($sformatf("drain_%0d", i), {56'd0, got[i]}, 64'h61 + 64'(i));
    end

    // two bytes queued, then exit with code 21
    con_rdy = 1'b0;
    putc(8'h31); putc(8'h32);
    wr(THI, 32'h0);
    wr(TLO, 32'h0000_002B);
    check("exit_halt", {63'd0, halt}, 64'd1);
    check("exit_code", {33'd0, exit_code}, 64'd21);
    rd_check("exit_th_lo", TLO, 32'h0);
    putc(8'h5A);
    rd_check("halt_th_lo", TLO, 32'h0000_005A);
    rd_check("halt_th_hi", THI, 32'h0101_0000);
    wr(THI, 32'h0);
    wr(TLO, 32'h0000_0001);
    check("halt_code_frozen", {33'd0, exit_code}, 64'd21);
    check("pre_rst_cvld", {63'd0, con_vld}, 64'd1);
    check("pre_rst_cdat", {56'd0, con_dat}, 64'h31);

    // one reset cycle
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check("rst2_cvld", {63'd0, con_vld}, 64'd0);
    check("rst2_halt", {63'd0, halt}, 64'd0);
    check("rst2_code", {33'd0, exit_code}, 64'd0);
    check("rst2_rdy",  {63'd0, tcb.rdy}, 64'd1);
    rd_check("rst2_th_lo", TLO, 32'h0);
    rd_check("rst2_th_hi", THI, 32'h0);
    rd_check("rst2_fh_lo", FLO, 32'h0);
    rd_check("rst2_fh_hi", FHI, 32'h0);

    // exit with code 0, then putchar is ignored
    con_rdy = 1'b1;
    wr(THI, 32'h0);
    wr(TLO, 32'h0000_0001);
    check("exit0_halt", {63'd0, halt}, 64'd1);
    check("exit0_code", {33'd0, exit_code}, 64'd0);
    rd_check("exit0_th_lo", TLO, 32'h0);
    putc(8'h41);
    repeat (4) begin
      @(negedge clk);
      check("halt_no_cvld", {63'd0, con_vld}, 64'd0);
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
`default_nettype wire
